lsu_subword: RTL and testbench
==============================

Name: lsu_subword

Overview:
- Load/store unit sitting directly upstream of the word-wide data memory. Sits between the core's execute stage and the memory.
- Accepts byte, halfword and word loads and stores from the core.
- Loads: extracts the addressed byte or halfword from the returned word and sign- or zero-extends it.
- Sub-word stores: the memory only writes whole words, so the block performs a two-cycle read-modify-write.
- Rejects misaligned accesses without touching memory.

Parameters:
- ADDR_W, 32, width of byte address (req_addr, mem_addr).
- DATA_W, 32, data word width; fixed at 32; other values unsupported.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  block can accept; equals (state==IDLE).
- req_we  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend; ignored for stores.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; byte in [7:0], half in [15:0].
- resp_valid  out  1  one-cycle completion pulse, registered.
- resp_rdata  out  32  extended load data, registered; 0 for store or misalign responses.
- misalign  out  1  qualifies resp_valid; request rejected.
- busy  out  1  (state!=IDLE); core stall.
- mem_addr  out  ADDR_W  {latched_addr[ADDR_W-1:2],2'b00}.
- mem_wdata  out  32  merged word during write state, else 0.
- mem_rdata  in  32  combinational read data; valid in the same cycle as mem_read.
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe; memory writes at the next posedge.

Behaviour:
- Reset:
  - state=IDLE; resp_valid=0; resp_rdata=0; misalign=0; all latches 0.
  - mem_read and mem_write are gated by !rst, so both are 0 during any reset cycle.
  - Reset mid-operation aborts the operation: no write, no response.
- Accept: at a posedge with req_valid && req_ready, latch addr, size, we, unsigned, wdata.
  - Requests while busy are ignored; the core must hold req_valid.
- Alignment check at accept:
  - Misaligned when: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
  - If misaligned: state stays IDLE; next cycle resp_valid=1, misalign=1, resp_rdata=0; no mem strobes.
- States: IDLE, LOAD, ST_WR, RMW_RD, RMW_WR.
  - IDLE -> LOAD on aligned load.
  - IDLE -> ST_WR on aligned word store.
  - IDLE -> RMW_RD on aligned byte or half store.
  - LOAD: mem_read=1. Register extended data into resp_rdata; -> IDLE; resp_valid=1 next cycle.
  - RMW_RD: mem_read=1. Capture mem_rdata into merge register; -> RMW_WR.
  - RMW_WR / ST_WR: mem_write=1, mem_wdata=merged word (ST_WR: req_wdata); -> IDLE; resp_valid=1 next cycle.
- Latency from the accept edge to the resp_valid cycle:
  - load 2 cycles; word store 2; sub-word store 3; misalign 1.
- Lane selection (little-endian):
  - Byte lane k=addr[1:0], bits [8k+7:8k].
  - Half lane bits [16*addr[1]+15:16*addr[1]].
  - Sign extension replicates the lane MSB.
- Merge: old word with only the selected lane replaced by req_wdata[7:0] or [15:0]; other lanes bit-identical.
- mem_read and mem_write are never both 1; both are 0 in IDLE.
- resp_valid is high for exactly one cycle. A new request may be accepted in the same cycle resp_valid is high.
- Back-to-back requests to the same word: a store followed by a load observes the stored value. The write edge precedes the next read cycle.

Test Plan:
- sw 0x8899AABB @0x10, then lb @0x13 -> 0xFFFFFF88; lbu @0x13 -> 0x00000088; lh @0x12 -> 0xFFFF8899; lhu @0x10 -> 0x0000AABB; each resp_valid exactly 2 cycles after accept.
- sb @0x11 wdata 0x12345677 -> mem_read 1 cycle then mem_write 1 cycle with mem_wdata 0x889977BB; resp_valid 3 cycles after accept; lw @0x10 returns 0x889977BB.
- sh @0x12 wdata 0x0000BEEF -> word becomes 0xBEEF77BB; lb @0x12 -> 0xFFFFFFEF.
- lw @0x06 and sh @0x03 -> resp_valid next cycle, misalign=1, resp_rdata=0, mem_read/mem_write never asserted, memory unchanged.
- rst pulsed during the RMW_RD cycle of sb @0x10 -> no mem_write; busy=0, req_ready=1, resp_valid=0 after reset; word unchanged.
- req_valid held high across a sub-word store with a queued lw -> second request accepted only on the first req_ready cycle; back-to-back sw 0x01020304 @0x20 then lw @0x20 -> 0x01020304.

Source files
------------

// File: rtl/lsu_subword.sv
// Sub-word load/store unit in front of a word-wide data memory.
// Handles byte/half extraction with extension, and read-modify-write for sub-word stores.
module lsu_subword #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              misalign,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_read,
    output logic              mem_write
);

    typedef enum logic [2:0] {StIdle, StLoad, StStWr, StRmwRd, StRmwWr} state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          size_q;
    logic                we_q;
    logic                uns_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   merge_q;

    logic                req_misaligned;
    logic [7:0]          byte_lane;
    logic [15:0]         half_lane;
    logic [DATA_W-1:0]   load_data;
    logic [DATA_W-1:0]   merged;

    always_comb begin
        case (req_size)
            2'b00:   req_misaligned = 1'b0;
            2'b01:   req_misaligned = req_addr[0];
            2'b10:   req_misaligned = (req_addr[1:0] != 2'b00);
            default: req_misaligned = 1'b1;
        endcase
    end

    // Little-endian lane pick from the word the memory returns this cycle.
    assign byte_lane = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign half_lane = mem_rdata[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        case (size_q)
            2'b00:   load_data = uns_q ? {24'b0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
            2'b01:   load_data = uns_q ? {16'b0, half_lane} : {{16{half_lane[15]}}, half_lane};
            default: load_data = mem_rdata;
        endcase
    end

    always_comb begin
        merged = mem_rdata;
        case (size_q)
            2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = mem_rdata;
        endcase
    end

    assign req_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    // Strobes are gated by reset so an aborted operation never reaches memory.
    assign mem_read  = !rst && (state_q == StLoad || state_q == StRmwRd);
    assign mem_write = !rst && (state_q == StStWr || state_q == StRmwWr);

    always_comb begin
        mem_wdata = '0;
        case (state_q)
            StStWr:  mem_wdata = wdata_q;
            StRmwWr: mem_wdata = merge_q;
            default: mem_wdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            size_q     <= 2'b00;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            wdata_q    <= '0;
            merge_q    <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            misalign   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            misalign   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        size_q  <= req_size;
                        we_q    <= req_we;
                        uns_q   <= req_unsigned;
                        wdata_q <= req_wdata;
                        if (req_misaligned) begin
                            resp_valid <= 1'b1;
                            misalign   <= 1'b1;
                        end else if (!req_we) begin
                            state_q <= StLoad;
                        end else if (req_size == 2'b10) begin
                            state_q <= StStWr;
                        end else begin
                            state_q <= StRmwRd;
                        end
                    end
                end
                StLoad: begin
                    resp_rdata <= load_data;
                    resp_valid <= 1'b1;
                    state_q    <= StIdle;
                end
                StRmwRd: begin
                    merge_q <= merged;
                    state_q <= StRmwWr;
                end
                StStWr, StRmwWr: begin
                    resp_valid <= 1'b1;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // we_q is kept for debug visibility; the state already encodes direction.
    logic unused_we;
    assign unused_we = we_q;

endmodule

// File: tb/tb_lsu_subword.sv
// Bench for lsu_subword: word memory model plus a byte-addressed reference of
// the architectural memory; directed cases followed by randomized traffic.
module tb_lsu_subword;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        misalign;
    logic        busy;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_read;
    logic        mem_write;

    lsu_subword #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .misalign     (misalign),
        .busy         (busy),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write)
    );

    always #5 clk = ~clk;

    // Memory the DUT talks to: combinational read, write on posedge.
    bit [31:0] mem [64];
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
    end

    // Strobe monitor; counters only grow, the main sequence diffs snapshots.
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          both_cnt = 0;
    logic [31:0] last_wdata = '0;
    always @(negedge clk) begin
        if (mem_read) rd_cnt++;
        if (mem_write) begin
            wr_cnt++;
            last_wdata = mem_wdata;
        end
        if (mem_read && mem_write) both_cnt++;
    end

    // Reference: plain byte array, little-endian.
    bit [7:0] rmem [256];

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] got_rdata;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    function automatic req_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata);
        req_t r;
        r.we = we; r.size = size; r.uns = uns; r.addr = addr; r.wdata = wdata;
        return r;
    endfunction

    function automatic logic [31:0] ref_word(input int w);
        return {rmem[4*w+3], rmem[4*w+2], rmem[4*w+1], rmem[4*w]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input req_t r);
        req_we = r.we; req_size = r.size; req_unsigned = r.uns;
        req_addr = r.addr; req_wdata = r.wdata;
    endtask

    // Issue one request from IDLE; optionally present the next request while it runs.
    task automatic xfer(input string tag, input req_t r, input bit chain, input req_t nx);
        int rd0, wr0, bo0, lat, bad_ready, n, a, exp_lat, exp_rd, exp_wr;
        bit mis;
        longint v;
        logic [31:0] exp_data, exp_word;
        rd0 = rd_cnt; wr0 = wr_cnt; bo0 = both_cnt;
        drive(r);
        req_valid = 1'b1;
        @(posedge clk); #1;
        if (chain) drive(nx); else req_valid = 1'b0;

        a = int'(r.addr[7:0]);
        n = (r.size == 2'd0) ? 1 : (r.size == 2'd1) ? 2 : 4;
        mis = (r.size == 2'd3) || (a % n != 0);
        exp_data = '0;
        if (mis) begin
            exp_lat = 1; exp_rd = 0; exp_wr = 0;
        end else if (!r.we) begin
            exp_lat = 2; exp_rd = 1; exp_wr = 0;
            v = 0;
            for (int i = 0; i < n; i++) v += longint'(rmem[a+i]) * (64'sd1 << (8*i));
            if (!r.uns && n < 4 && v >= (64'sd1 << (8*n-1))) v -= (64'sd1 << (8*n));
            exp_data = v[31:0];
        end else begin
            exp_lat = (n == 4) ? 2 : 3;
            exp_rd  = (n == 4) ? 0 : 1;
            exp_wr  = 1;
            for (int i = 0; i < n; i++) rmem[a+i] = 8'(r.wdata >> (8*i));
        end
        exp_word = ref_word(a / 4);

        lat = 1; bad_ready = 0;
        while (!resp_valid && lat < 8) begin
            if (req_ready) bad_ready++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        check({tag, ".mis"}, {31'b0, misalign}, {31'b0, mis});
        check({tag, ".rdata"}, resp_rdata, exp_data);
        check({tag, ".nrd"}, 32'(rd_cnt - rd0), 32'(exp_rd));
        check({tag, ".nwr"}, 32'(wr_cnt - wr0), 32'(exp_wr));
        check({tag, ".both"}, 32'(both_cnt - bo0), 32'd0);
        check({tag, ".ready"}, 32'(bad_ready), 32'd0);
        if (exp_wr != 0) check({tag, ".wdata"}, last_wdata, exp_word);
        got_rdata = resp_rdata;
    endtask

    initial begin
        req_t none, r, nx, q1, q2;
        int wr0, rv_seen, bad_words;
        bit chain;
        none = mk(1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1; req_valid = 1'b0;
        drive(none);

        repeat (2) @(posedge clk);
        #1;
        check("rst.resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst.resp_rdata", resp_rdata, 32'd0);
        check("rst.misalign", {31'b0, misalign}, 32'd0);
        check("rst.busy", {31'b0, busy}, 32'd0);
        check("rst.ready", {31'b0, req_ready}, 32'd1);
        check("rst.strobes", {30'b0, mem_read, mem_write}, 32'd0);
        check("rst.mem_addr", mem_addr, 32'd0);
        rst = 1'b0;

        xfer("sw10", mk(1'b1, 2'd2, 1'b0, 32'h10, 32'h8899AABB), 1'b0, none);
        xfer("lb13", mk(1'b0, 2'd0, 1'b0, 32'h13, 32'h0), 1'b0, none);
        check("lb13.const", got_rdata, 32'hFFFFFF88);
        xfer("lbu13", mk(1'b0, 2'd0, 1'b1, 32'h13, 32'h0), 1'b0, none);
        check("lbu13.const", got_rdata, 32'h00000088);
        xfer("lh12", mk(1'b0, 2'd1, 1'b0, 32'h12, 32'h0), 1'b0, none);
        check("lh12.const", got_rdata, 32'hFFFF8899);
        xfer("lhu10", mk(1'b0, 2'd1, 1'b1, 32'h10, 32'h0), 1'b0, none);
        check("lhu10.const", got_rdata, 32'h0000AABB);
        xfer("sb11", mk(1'b1, 2'd0, 1'b0, 32'h11, 32'h12345677), 1'b0, none);
        check("sb11.const", last_wdata, 32'h889977BB);
        xfer("lw10a", mk(1'b0, 2'd2, 1'b0, 32'h10, 32'h0), 1'b0, none);
        check("lw10a.const", got_rdata, 32'h889977BB);
        xfer("sh12", mk(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000BEEF), 1'b0, none);
        xfer("lw10b", mk(1'b0, 2'd2, 1'b0, 32'h10, 32'h0), 1'b0, none);
        check("lw10b.const", got_rdata, 32'hBEEF77BB);
        xfer("lb12", mk(1'b0, 2'd0, 1'b0, 32'h12, 32'h0), 1'b0, none);
        check("lb12.const", got_rdata, 32'hFFFFFFEF);
        xfer("lw06", mk(1'b0, 2'd2, 1'b0, 32'h06, 32'h0), 1'b0, none);
        xfer("sh03", mk(1'b1, 2'd1, 1'b0, 32'h03, 32'hFFFF), 1'b0, none);
        xfer("lw04", mk(1'b0, 2'd2, 1'b0, 32'h04, 32'h0), 1'b0, none);

        // Reset lands during the read half of a sub-word store.
        wr0 = wr_cnt;
        drive(mk(1'b1, 2'd0, 1'b0, 32'h10, 32'h55));
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort.busy", {31'b0, busy}, 32'd0);
        check("abort.ready", {31'b0, req_ready}, 32'd1);
        rv_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (resp_valid) rv_seen++;
            @(posedge clk); #1;
        end
        check("abort.resp", 32'(rv_seen), 32'd0);
        check("abort.nwr", 32'(wr_cnt - wr0), 32'd0);
        xfer("abort.lw10", mk(1'b0, 2'd2, 1'b0, 32'h10, 32'h0), 1'b0, none);
        check("abort.const", got_rdata, 32'hBEEF77BB);

        // Queued requests: req_valid held across the first operation.
        q1 = mk(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000A5);
        q2 = mk(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        xfer("q.sb11", q1, 1'b1, q2);
        xfer("q.lw10", q2, 1'b0, none);
        check("q.const", got_rdata, 32'hBEEFA5BB);
        q1 = mk(1'b1, 2'd2, 1'b0, 32'h20, 32'h01020304);
        q2 = mk(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        xfer("b2b.sw20", q1, 1'b1, q2);
        xfer("b2b.lw20", q2, 1'b0, none);
        check("b2b.const", got_rdata, 32'h01020304);

        // Randomized traffic, sometimes with the next request held valid.
        r = none;
        r.addr = 32'h0;
        for (int k = 0; k < 300; k++) begin
            logic [1:0] sz;
            logic [7:0] ad;
            sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'(($urandom_range(0, 2)));
            ad = 8'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) ad[0] = 1'b0;
                if (sz == 2'd2) ad[1:0] = 2'b00;
            end
            nx = mk(1'($urandom), sz, 1'($urandom), {24'b0, ad}, $urandom);
            if (k == 0) begin
                r = nx;
            end else begin
                chain = 1'($urandom);
                xfer("rand", r, chain, nx);
                r = nx;
            end
        end
        xfer("rand.last", r, 1'b0, none);

        bad_words = 0;
        for (int w = 0; w < 64; w++) begin
            if (mem[w] !== ref_word(w)) bad_words++;
        end
        check("final.mem", 32'(bad_words), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
